// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the CPU control unit
package cpu_ctrl_pkg;

  // Controller states
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    ALU    = 4'd2,
    LD     = 4'd3,
    ST     = 4'd4,
    JR     = 4'd5,
    BR     = 4'd6,
    HALT   = 4'd7,
    ERR    = 4'd8
  } state_t;

  // Instruction class codes, ir[11:9]
  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [2:0] CLS_LD   = 3'b001;
  localparam logic [2:0] CLS_ST   = 3'b010;
  localparam logic [2:0] CLS_JR   = 3'b011;
  localparam logic [2:0] CLS_BR   = 3'b100;
  localparam logic [2:0] CLS_HALT = 3'b111;

  // Branch condition codes, ir[15:12]; 7..15 never taken
  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_Z  = 4'd1;
  localparam logic [3:0] CC_NZ = 4'd2;
  localparam logic [3:0] CC_C  = 4'd3;
  localparam logic [3:0] CC_NC = 4'd4;
  localparam logic [3:0] CC_N  = 4'd5;
  localparam logic [3:0] CC_NN = 4'd6;

  // Bit positions inside the {C,N,Z} status register
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/cu_cond_eval.sv
// rtl/cu_cond_eval.sv - branch condition evaluator against stored flags
module cu_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [2:0] flags,
  output logic       take
);

  // Map the condition code onto the stored {C,N,Z} flags
  always_comb begin
    take = 1'b0;
    case (cond)
      CC_AL:   take = 1'b1;
      CC_Z:    take = flags[FLAG_Z];
      CC_NZ:   take = ~flags[FLAG_Z];
      CC_C:    take = flags[FLAG_C];
      CC_NC:   take = ~flags[FLAG_C];
      CC_N:    take = flags[FLAG_N];
      CC_NN:   take = ~flags[FLAG_N];
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/execute sequencer for the 16-bit CPU
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        c_in,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        mem_rdy,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_sel,
  output logic        adr_sel,
  output logic        w_en,
  output logic        s_sel,
  output logic        mr_en,
  output logic        mw_en,
  output logic [2:0]  flags,
  output logic        halted,
  output logic        err
);

  // Counter value on the last tolerated not-ready cycle
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       timeout;
  logic       br_take;

  // Operand/offset bits belong to the datapath, not the sequencer
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[8:0];

  cu_cond_eval u_cond_eval (
    .cond  (ir[15:12]),
    .flags (flags),
    .take  (br_take)
  );

  assign mem_state = (state == FETCH) || (state == LD) || (state == ST);
  // mem_rdy on the final wait cycle still wins over the timeout
  assign timeout   = mem_state && !mem_rdy && (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Consecutive not-ready counter, restarted whenever the state moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wait_cnt <= 8'd0;
    else if (state_nxt != state)    wait_cnt <= 8'd0;
    else if (mem_state && !mem_rdy) wait_cnt <= wait_cnt + 8'd1;
  end

  // Status register captures the ALU flags as the ALU state is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             flags <= 3'b000;
    else if (state == ALU) flags <= {c_in, n_in, z_in};
  end

  // Next-state and strobe decode; reset forces every strobe low at once
  always_comb begin
    state_nxt = state;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    pc_sel    = 1'b0;
    adr_sel   = 1'b0;
    w_en      = 1'b0;
    s_sel     = 1'b0;
    mr_en     = 1'b0;
    mw_en     = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    case (state)
      FETCH: begin
        mr_en = 1'b1;
        if (mem_rdy) begin
          ir_ld     = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = DECODE;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      DECODE: begin
        case (ir[11:9])
          CLS_ALU:  state_nxt = ALU;
          CLS_LD:   state_nxt = LD;
          CLS_ST:   state_nxt = ST;
          CLS_JR:   state_nxt = JR;
          CLS_BR:   state_nxt = BR;
          CLS_HALT: state_nxt = HALT;
          default:  state_nxt = ERR;
        endcase
      end
      ALU: begin
        w_en      = 1'b1;
        state_nxt = FETCH;
      end
      LD: begin
        adr_sel = 1'b1;
        mr_en   = 1'b1;
        s_sel   = 1'b1;
        w_en    = mem_rdy;
        if (mem_rdy)      state_nxt = FETCH;
        else if (timeout) state_nxt = ERR;
      end
      ST: begin
        adr_sel = 1'b1;
        mw_en   = 1'b1;
        if (mem_rdy)      state_nxt = FETCH;
        else if (timeout) state_nxt = ERR;
      end
      JR: begin
        pc_sel    = 1'b1;
        pc_ld     = 1'b1;
        state_nxt = FETCH;
      end
      BR: begin
        pc_ld     = br_take;
        state_nxt = FETCH;
      end
      HALT:    halted    = 1'b1;
      ERR:     err       = 1'b1;
      default: state_nxt = ERR;
    endcase
    if (reset) begin
      ir_ld   = 1'b0;
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      pc_sel  = 1'b0;
      adr_sel = 1'b0;
      w_en    = 1'b0;
      s_sel   = 1'b0;
      mr_en   = 1'b0;
      mw_en   = 1'b0;
      halted  = 1'b0;
      err     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - self-checking bench for cpu_control_unit
module tb_cpu_control_unit;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        c_in = 1'b0;
  logic        n_in = 1'b0;
  logic        z_in = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        ir_ld, pc_inc, pc_ld, pc_sel, adr_sel, w_en, s_sel, mr_en, mw_en;
  logic [2:0]  flags;
  logic        halted, err;

  always #5 clk = ~clk;

  cpu_control_unit #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .ir      (ir),
    .c_in    (c_in),
    .n_in    (n_in),
    .z_in    (z_in),
    .mem_rdy (mem_rdy),
    .ir_ld   (ir_ld),
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .pc_sel  (pc_sel),
    .adr_sel (adr_sel),
    .w_en    (w_en),
    .s_sel   (s_sel),
    .mr_en   (mr_en),
    .mw_en   (mw_en),
    .flags   (flags),
    .halted  (halted),
    .err     (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Instruction-level model: which part of the instruction we are in,
  // which class was decoded, stored flags, and the current run of waits.
  bit         m_err, m_halt;
  int         m_phase;   // 0 fetching, 1 decoding, 2 executing
  logic [2:0] m_cls;
  logic [2:0] m_flags;
  int         m_waits;

  // Output vector: {ir_ld,pc_inc,pc_ld,pc_sel,adr_sel,w_en,s_sel,mr_en,mw_en}_{flags}_{halted,err}
  logic [13:0] got, exp_v;

  task automatic model_reset();
    m_err = 0; m_halt = 0; m_phase = 0; m_cls = 3'd0; m_flags = 3'b000; m_waits = 0;
  endtask

  // Odd codes test a flag, even codes its complement; pairs are Z, C, N
  function automatic logic br_taken(input logic [3:0] cond, input logic [2:0] f);
    int   sel;
    logic v;
    if (cond == 4'd0) return 1'b1;
    if (cond > 4'd6) return 1'b0;
    sel = (int'(cond) + 1) / 2;
    v = (sel == 1) ? f[0] : (sel == 2) ? f[2] : f[1];
    return cond[0] ? v : ~v;
  endfunction

  function automatic logic [13:0] model_out();
    logic [8:0] s;
    logic [1:0] hs;
    s = 9'd0;
    hs = 2'b00;
    if (reset) return 14'd0;
    if (m_err) hs = 2'b01;
    else if (m_halt) hs = 2'b10;
    else if (m_phase == 0) s = {mem_rdy, mem_rdy, 7'b0000010};
    else if (m_phase == 2) begin
      case (m_cls)
        3'd0:    s = 9'b000001000;
        3'd1:    s = {4'b0000, 1'b1, mem_rdy, 3'b110};
        3'd2:    s = 9'b000010001;
        3'd3:    s = 9'b001100000;
        default: s = {2'b00, br_taken(ir[15:12], m_flags), 6'b000000};
      endcase
    end
    return {s, m_flags, hs};
  endfunction

  task automatic mem_access(input int next_phase);
    if (mem_rdy) begin
      m_waits = 0;
      m_phase = next_phase;
    end else begin
      m_waits++;
      if (m_waits >= WAIT_MAX) m_err = 1;
    end
  endtask

  task automatic model_step();
    if (reset || m_err || m_halt) return;
    if (m_phase == 0) mem_access(1);
    else if (m_phase == 1) begin
      m_cls = ir[11:9];
      if (m_cls == 3'd7) m_halt = 1;
      else if (m_cls > 3'd4) m_err = 1;
      else m_phase = 2;
    end else begin
      if (m_cls == 3'd0) begin
        m_flags = {c_in, n_in, z_in};
        m_phase = 0;
      end else if (m_cls == 3'd1 || m_cls == 3'd2) mem_access(0);
      else m_phase = 0;
    end
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic compare();
    if (reset) model_reset();
    got = {ir_ld, pc_inc, pc_ld, pc_sel, adr_sel, w_en, s_sel, mr_en, mw_en, flags, halted, err};
    exp_v = model_out();
    chk($sformatf("model cycle %0d", cyc), got, exp_v);
    chk($sformatf("mr_mw_excl cycle %0d", cyc), {13'd0, got[6] & got[5]}, 14'd0);
    chk($sformatf("wen_pcld_excl cycle %0d", cyc), {13'd0, got[8] & got[11]}, 14'd0);
  endtask

  task automatic step(input logic [15:0] ir_v, input logic rdy, input logic [2:0] cnz);
    @(negedge clk);
    reset = 1'b0;
    ir = ir_v;
    mem_rdy = rdy;
    {c_in, n_in, z_in} = cnz;
    #1 compare();
    @(posedge clk);
    cyc++;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_rdy = 1'($urandom);
    #1 compare();
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic [15:0] rir;
    int          cls;
    model_reset();

    // 1: ALU instruction, flags captured
    do_reset();
    chk("t1 reset", got, 14'd0);
    step(16'h0000, 1'b1, 3'b101); chk("t1 fetch", got, 14'b110000010_000_00);
    step(16'h0000, 1'b1, 3'b101); chk("t1 decode", got, 14'b000000000_000_00);
    step(16'h0000, 1'b1, 3'b101); chk("t1 alu", got, 14'b000001000_000_00);
    step(16'h1200, 1'b1, 3'b010); chk("t1 flags", got, 14'b110000010_101_00);

    // 2: LD with two wait cycles
    step(16'h1200, 1'b1, 3'b010); chk("t2 decode", got, 14'b000000000_101_00);
    step(16'h1200, 1'b0, 3'b010); chk("t2 ld wait1", got, 14'b000010110_101_00);
    step(16'h1200, 1'b0, 3'b010); chk("t2 ld wait2", got, 14'b000010110_101_00);
    step(16'h1200, 1'b1, 3'b010); chk("t2 ld done", got, 14'b000011110_101_00);

    // 3: branches with Z=1
    step(16'h1800, 1'b1, 3'b000);
    step(16'h1800, 1'b1, 3'b000);
    step(16'h1800, 1'b1, 3'b000); chk("t3 br z taken", got, 14'b001000000_101_00);
    step(16'h2800, 1'b1, 3'b000);
    step(16'h2800, 1'b1, 3'b000);
    step(16'h2800, 1'b1, 3'b000); chk("t3 br nz not taken", got, 14'b000000000_101_00);
    step(16'h0400, 1'b1, 3'b000); chk("t3 back to fetch", got, 14'b110000010_101_00);

    // 4: ST timeout
    step(16'h0400, 1'b1, 3'b000);
    for (int i = 0; i < WAIT_MAX; i++) begin
      step(16'h0400, 1'b0, 3'b000);
      chk($sformatf("t4 st wait %0d", i), got, 14'b000010001_101_00);
    end
    for (int i = 0; i < 3; i++) begin
      step(16'h0400, 1'b0, 3'b000);
      chk($sformatf("t4 err %0d", i), got, 14'b000000000_101_01);
    end

    // 5: HALT and illegal class
    do_reset();
    step(16'h0E00, 1'b1, 3'b000);
    step(16'h0E00, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(16'h0E00, 1'b1, 3'b000);
      chk($sformatf("t5 halt %0d", i), got, 14'b000000000_000_10);
    end
    do_reset();
    step(16'h0A00, 1'b1, 3'b000);
    step(16'h0A00, 1'b1, 3'b000);
    step(16'h0A00, 1'b1, 3'b000); chk("t5 illegal", got, 14'b000000000_000_01);

    // 6: async reset during an LD wait
    do_reset();
    step(16'h1200, 1'b1, 3'b000);
    step(16'h1200, 1'b1, 3'b000);
    step(16'h1200, 1'b0, 3'b000); chk("t6 ld wait", got, 14'b000010110_000_00);
    @(negedge clk);
    mem_rdy = 1'b0;
    #1 compare();
    #2 reset = 1'b1;
    #1 compare();
    chk("t6 async drop", got, 14'd0);
    @(posedge clk);
    cyc++;
    step(16'h1200, 1'b0, 3'b000); chk("t6 first fetch", got, 14'b000000010_000_00);

    // Randomized episodes against the model
    rir = 16'h0000;
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        if (m_phase == 0) begin
          cls = ($urandom_range(0, 19) < 17) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
          rir = {4'($urandom_range(0, 15)), 3'(cls), 9'($urandom)};
        end
        step(rir, 1'($urandom_range(0, 9) < 7), 3'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
